// File: rtl/wrr_pkg.sv
// Shared types and sizing for the credit-aware weighted round-robin VC scheduler.
package wrr_pkg;

    localparam int NUM_VC     = 4;
    localparam int VC_ID_W    = 2;
    localparam int WEIGHT_W   = 3;
    localparam int CREDIT_W   = 3;
    localparam int MAX_CREDIT = 4;

    typedef logic [VC_ID_W-1:0] vc_id_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_VC-1:0] vc_onehot(vc_id_t id);
        return NUM_VC'(1) << id;
    endfunction

endpackage

// File: rtl/vc_wrr_scheduler_if.sv
// Request/config/credit inputs and grant outputs of the VC scheduler.
interface vc_wrr_scheduler_if;
    import wrr_pkg::*;

    logic [NUM_VC-1:0]   req;
    logic                cfg_we;
    vc_id_t              cfg_vc;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic [NUM_VC-1:0]   credit_return;
    logic                out_ready;
    logic                grant_valid;
    vc_id_t              grant_id;
    logic [NUM_VC-1:0]   grant_onehot;
    logic                credit_err;

    modport master (
        output req, cfg_we, cfg_vc, cfg_weight, credit_return, out_ready,
        input  grant_valid, grant_id, grant_onehot, credit_err
    );

    modport slave (
        input  req, cfg_we, cfg_vc, cfg_weight, credit_return, out_ready,
        output grant_valid, grant_id, grant_onehot, credit_err
    );

endinterface

// File: rtl/vc_rr_pick.sv
// Rotating-priority picker: first eligible VC at or after i_start, wrapping mod NUM_VC.
module vc_rr_pick
    import wrr_pkg::*;
(
    input  logic [NUM_VC-1:0] i_elig,
    input  vc_id_t            i_start,
    output logic              o_found,
    output vc_id_t            o_pick_id
);

    vc_id_t w_idx;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_found   = 1'b0;
        o_pick_id = i_start;
        w_idx     = i_start;
        for (int k = 0; k < NUM_VC; k++) begin
            w_idx = i_start + vc_id_t'(k);
            if (!o_found && i_elig[w_idx]) begin
                o_found   = 1'b1;
                o_pick_id = w_idx;
            end
        end
    end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Credit-aware weighted round-robin scheduler: weight table, per-VC credits,
// quantum counter and a registered grant with valid/ready handshake.
module vc_wrr_scheduler
    import wrr_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    vc_wrr_scheduler_if.slave bus
);

    logic [WEIGHT_W-1:0] r_weight [NUM_VC];
    logic [CREDIT_W-1:0] r_credit [NUM_VC];
    vc_id_t              r_cur;
    logic [WEIGHT_W-1:0] r_quantum;
    state_t              r_state;
    vc_id_t              r_grant_id;
    logic [NUM_VC-1:0]   r_grant_onehot;
    logic                r_credit_err;

    logic                w_fire;
    logic [NUM_VC-1:0]   w_fire_vc;
    logic [CREDIT_W-1:0] w_credit_nx [NUM_VC];
    logic [NUM_VC-1:0]   w_credit_ovf;
    logic [NUM_VC-1:0]   w_elig;
    logic [WEIGHT_W-1:0] w_quantum_nx;
    logic                w_sel_en;
    logic                w_stay;
    logic                w_found;
    vc_id_t              w_pick_id;

    assign w_fire       = (r_state == GRANT) && bus.out_ready;
    assign w_fire_vc    = w_fire ? vc_onehot(r_grant_id) : '0;
    assign w_quantum_nx = w_fire ? (r_quantum - WEIGHT_W'(1)) : r_quantum;
    assign w_sel_en     = (r_state == IDLE) || w_fire;
    assign w_stay       = w_elig[r_cur] && (w_quantum_nx != '0);

    // A fire and a return on the same VC cancel; a return into a full counter is an error.
    always_comb begin
        w_credit_ovf = '0;
        w_elig       = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_credit_nx[i] = r_credit[i];
            if (w_fire_vc[i] && !bus.credit_return[i]) begin
                w_credit_nx[i] = r_credit[i] - CREDIT_W'(1);
            end else if (bus.credit_return[i] && !w_fire_vc[i]) begin
                if (r_credit[i] == CREDIT_W'(MAX_CREDIT)) begin
                    w_credit_ovf[i] = 1'b1;
                end else begin
                    w_credit_nx[i] = r_credit[i] + CREDIT_W'(1);
                end
            end
            w_elig[i] = bus.req[i] && (w_credit_nx[i] != '0) && (r_weight[i] != '0);
        end
    end

    vc_rr_pick u_pick (
        .i_elig    (w_elig),
        .i_start   (r_cur + vc_id_t'(1)),
        .o_found   (w_found),
        .o_pick_id (w_pick_id)
    );

    // NOTE: the weight table is only four entries, so it is reset like ordinary registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_weight[i] <= WEIGHT_W'(1);
                r_credit[i] <= CREDIT_W'(MAX_CREDIT);
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                r_credit[i] <= w_credit_nx[i];
            end
            if (|w_credit_ovf) begin
                r_credit_err <= 1'b1;
            end
            if (bus.cfg_we) begin
                r_weight[bus.cfg_vc] <= bus.cfg_weight;
            end
        end
    end

    // A held grant (valid, not ready) is never re-evaluated, so grant_id stays stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cur          <= vc_id_t'(NUM_VC - 1);
            r_quantum      <= '0;
            r_grant_id     <= '0;
            r_grant_onehot <= '0;
        end else if (w_sel_en) begin
            if (w_stay) begin
                r_state        <= GRANT;
                r_quantum      <= w_quantum_nx;
                r_grant_id     <= r_cur;
                r_grant_onehot <= vc_onehot(r_cur);
            end else if (w_found) begin
                r_state        <= GRANT;
                r_cur          <= w_pick_id;
                r_quantum      <= r_weight[w_pick_id];
                r_grant_id     <= w_pick_id;
                r_grant_onehot <= vc_onehot(w_pick_id);
            end else begin
                r_state        <= IDLE;
                r_quantum      <= w_quantum_nx;
                r_grant_onehot <= '0;
            end
        end
    end

    assign bus.grant_valid  = (r_state == GRANT);
    assign bus.grant_id     = r_grant_id;
    assign bus.grant_onehot = r_grant_onehot;
    assign bus.credit_err   = r_credit_err;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Self-checking bench for vc_wrr_scheduler: directed scenarios plus randomized traffic
// compared against a transaction-level reference model of the scheduling rules.
module tb_vc_wrr_scheduler;
    import wrr_pkg::*;

    logic clk;
    logic reset;
    vc_wrr_scheduler_if bus ();

    vc_wrr_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_w [NUM_VC];
    int m_c [NUM_VC];
    int m_cur;
    int m_q;
    bit m_valid;
    int m_id;
    bit m_err;

    task automatic model_reset();
        for (int i = 0; i < NUM_VC; i++) begin
            m_w[i] = 1;
            m_c[i] = MAX_CREDIT;
        end
        m_cur = NUM_VC - 1;
        m_q = 0;
        m_valid = 0;
        m_id = 0;
        m_err = 0;
    endtask

    // Advances the model by one clock using the inputs currently driven on bus.
    task automatic model_step();
        bit fire;
        int nx [NUM_VC];
        bit el [NUM_VC];
        int qn;
        int base;
        bit found;
        fire = m_valid && bus.out_ready;
        for (int i = 0; i < NUM_VC; i++) begin
            bit fi;
            bit ri;
            fi = fire && (m_id == i);
            ri = bus.credit_return[i];
            nx[i] = m_c[i];
            if (fi && !ri) nx[i] = m_c[i] - 1;
            else if (ri && !fi) begin
                if (m_c[i] == MAX_CREDIT) m_err = 1;
                else nx[i] = m_c[i] + 1;
            end
            el[i] = bus.req[i] && (nx[i] > 0) && (m_w[i] > 0);
        end
        if (!m_valid || fire) begin
            qn = fire ? m_q - 1 : m_q;
            if (el[m_cur] && qn > 0) begin
                m_q = qn;
                m_valid = 1;
                m_id = m_cur;
            end else begin
                found = 0;
                base = m_cur;
                for (int k = 1; k <= NUM_VC; k++) begin
                    int v;
                    v = (base + k) % NUM_VC;
                    if (!found && el[v]) begin
                        found = 1;
                        m_cur = v;
                        m_q = m_w[v];
                        m_valid = 1;
                        m_id = v;
                    end
                end
                if (!found) begin
                    m_valid = 0;
                    m_q = qn;
                end
            end
        end
        if (bus.cfg_we) m_w[int'(bus.cfg_vc)] = int'(bus.cfg_weight);
        for (int i = 0; i < NUM_VC; i++) m_c[i] = nx[i];
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_VC-1:0] echo();
        return (m_valid && bus.out_ready) ? 4'(1 << m_id) : 4'b0000;
    endfunction

    function automatic logic [NUM_VC-1:0] exp_onehot();
        return m_valid ? 4'(1 << m_id) : 4'b0000;
    endfunction

    task automatic drive_idle();
        bus.req           = '0;
        bus.cfg_we        = 1'b0;
        bus.cfg_vc        = '0;
        bus.cfg_weight    = '0;
        bus.credit_return = '0;
        bus.out_ready     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive_idle();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive_idle();
        model_reset();
        #2;
        n_cmp++;
        if (bus.grant_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.grant_valid); end
        n_cmp++;
        if (bus.grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", bus.grant_id); end
        n_cmp++;
        if (bus.grant_onehot !== 4'b0000) begin n_bad++; $display("FAIL reset_onehot: got %b want 0000", bus.grant_onehot); end
        n_cmp++;
        if (bus.credit_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.credit_err); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_default_rr();
        int seq [4] = '{0, 1, 2, 3};
        do_reset();
        bus.req = 4'b1111;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.credit_return = echo();
            tick();
            n_cmp++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'(seq[c % 4])) begin
                n_bad++;
                $display("FAIL default_rr[%0d]: got v=%b id=%0d want v=1 id=%0d", c, bus.grant_valid, bus.grant_id, seq[c % 4]);
            end
            n_cmp++;
            if (bus.grant_onehot !== exp_onehot()) begin
                n_bad++;
                $display("FAIL default_rr_onehot[%0d]: got %b want %b", c, bus.grant_onehot, exp_onehot());
            end
        end
    endtask

    task automatic test_weighted();
        int wts [4] = '{3, 1, 2, 1};
        int seq [7] = '{0, 0, 0, 1, 2, 2, 3};
        do_reset();
        for (int v = 0; v < NUM_VC; v++) begin
            bus.cfg_we = 1'b1;
            bus.cfg_vc = 2'(v);
            bus.cfg_weight = 3'(wts[v]);
            tick();
        end
        bus.cfg_we = 1'b0;
        bus.req = 4'b1111;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            bus.credit_return = echo();
            tick();
            n_cmp++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'(seq[c % 7])) begin
                n_bad++;
                $display("FAIL weighted[%0d]: got v=%b id=%0d want v=1 id=%0d", c, bus.grant_valid, bus.grant_id, seq[c % 7]);
            end
        end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        do_reset();
        bus.req = 4'b0001;
        bus.out_ready = 1'b0;
        tick();
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin
                n_bad++;
                $display("FAIL hold[%0d]: got v=%b id=%0d want v=1 id=0", c, bus.grant_valid, bus.grant_id);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        bus.req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            if (bus.grant_valid && bus.out_ready) fires++;
            tick();
        end
        n_cmp++;
        if (fires !== 1) begin n_bad++; $display("FAIL hold_fires: got %0d want 1", fires); end
        n_cmp++;
        if (int'(dut.r_credit[0]) !== 3) begin n_bad++; $display("FAIL hold_credit0: got %0d want 3", dut.r_credit[0]); end
        n_cmp++;
        if (bus.grant_valid !== 1'b0) begin n_bad++; $display("FAIL hold_idle: got %b want 0", bus.grant_valid); end
    endtask

    task automatic test_credit_exhaust();
        int fires = 0;
        do_reset();
        bus.cfg_we = 1'b1;
        bus.cfg_vc = 2'd2;
        bus.cfg_weight = 3'd7;
        tick();
        bus.cfg_we = 1'b0;
        bus.req = 4'b0100;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.grant_valid && bus.out_ready) fires++;
            tick();
        end
        n_cmp++;
        if (fires !== 4) begin n_bad++; $display("FAIL exhaust_fires: got %0d want 4", fires); end
        n_cmp++;
        if (bus.grant_valid !== 1'b0) begin n_bad++; $display("FAIL exhaust_idle: got %b want 0", bus.grant_valid); end
        bus.credit_return = 4'b0100;
        tick();
        bus.credit_return = 4'b0000;
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd2) begin
            n_bad++;
            $display("FAIL exhaust_return: got v=%b id=%0d want v=1 id=2", bus.grant_valid, bus.grant_id);
        end
    endtask

    task automatic test_weight_zero();
        int bad_ids = 0;
        do_reset();
        bus.cfg_we = 1'b1;
        bus.cfg_vc = 2'd1;
        bus.cfg_weight = 3'd0;
        tick();
        bus.cfg_we = 1'b0;
        bus.req = 4'b0011;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.credit_return = echo();
            tick();
            if (!bus.grant_valid || bus.grant_id !== 2'd0) bad_ids++;
        end
        n_cmp++;
        if (bad_ids !== 0) begin n_bad++; $display("FAIL weight_zero: got %0d non-VC0 cycles want 0", bad_ids); end
        bus.req = 4'b0000;
        bus.credit_return = echo() | 4'b1000;
        tick();
        bus.credit_return = 4'b0000;
        n_cmp++;
        if (bus.credit_err !== 1'b1) begin n_bad++; $display("FAIL credit_err: got %b want 1", bus.credit_err); end
        n_cmp++;
        if (int'(dut.r_credit[3]) !== MAX_CREDIT) begin n_bad++; $display("FAIL credit3_sat: got %0d want %0d", dut.r_credit[3], MAX_CREDIT); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b1000;
        bus.out_ready = 1'b0;
        tick();
        n_cmp++;
        if (bus.grant_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre: got %b want 1", bus.grant_valid); end
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 4'b0000) begin
            n_bad++;
            $display("FAIL areset_drop: got v=%b oh=%b want v=0 oh=0000", bus.grant_valid, bus.grant_onehot);
        end
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd3 || bus.grant_onehot !== 4'b1000) begin
            n_bad++;
            $display("FAIL areset_regrant: got v=%b id=%0d oh=%b want v=1 id=3 oh=1000", bus.grant_valid, bus.grant_id, bus.grant_onehot);
        end
        n_cmp++;
        if (m_q !== 1) begin n_bad++; $display("FAIL areset_quantum: got %0d want 1", m_q); end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.req = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.credit_return = 4'($urandom) & 4'($urandom);
            bus.cfg_we = ($urandom_range(0, 7) == 0);
            bus.cfg_vc = 2'($urandom);
            bus.cfg_weight = 3'($urandom);
            tick();
            n_cmp++;
            if (bus.grant_valid !== m_valid || (m_valid && bus.grant_id !== 2'(m_id)) ||
                bus.grant_onehot !== exp_onehot() || bus.credit_err !== m_err) begin
                n_bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got v=%b id=%0d oh=%b err=%b want v=%b id=%0d oh=%b err=%b",
                             c, bus.grant_valid, bus.grant_id, bus.grant_onehot, bus.credit_err,
                             m_valid, m_id, exp_onehot(), m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        drive_idle();
        test_reset();
        test_default_rr();
        test_weighted();
        test_backpressure();
        test_credit_exhaust();
        test_weight_zero();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
